// File: rtl/mac_dot_scheduler_pkg.sv
// Shared definitions for the dot-product scheduler: FSM encoding and default widths.
package mac_dot_scheduler_pkg;

  localparam int DEF_BITS     = 8;
  localparam int DEF_LEN_W    = 8;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_ACC_BITS = 24;

  // Depth of the external MAC pipeline; the scheduler counts done pulses and
  // never relies on this value, it only documents the expected timing.
  localparam int MAC_LATENCY  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mac_dot_scheduler_acc.sv
// Signed accumulator: sign-extends each MAC product and adds it with
// two's-complement wrap. Width is chosen by the parent so N full-scale
// products cannot overflow.
module dot_accumulator #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             add_en,
  input  logic [IN_W-1:0]  din,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] din_ext;

  // Sign extension of the product to accumulator width.
  always_comb begin
    din_ext = {{(ACC_W-IN_W){din[IN_W-1]}}, din};
  end

  // Accumulator register: clear has priority over add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + din_ext;
    end
  end

endmodule

// File: rtl/mac_dot_scheduler.sv
// Dot-product scheduler: reads N operand pairs from two 1-cycle-read buffers,
// streams them into an external signed MAC, counts its done pulses and
// presents the accumulated sum with a one-cycle out_valid pulse.
//
// Handshake: start is a one-cycle request honoured only when busy=0 (IDLE);
// len/a_base/b_base are captured on that cycle. out_valid is a one-cycle
// pulse while result carries the final sum; result then holds until the next
// completed operation. A start coinciding with out_valid is ignored.
module mac_dot_scheduler
  import mac_dot_scheduler_pkg::*;
#(
  parameter int BITS     = DEF_BITS,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ACC_BITS = DEF_ACC_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic [ADDR_W-1:0]   a_base,
  input  logic [ADDR_W-1:0]   b_base,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   a_addr,
  output logic [ADDR_W-1:0]   b_addr,
  input  logic [BITS-1:0]     a_rdata,
  input  logic [BITS-1:0]     b_rdata,
  output logic                mac_enable,
  output logic [BITS-1:0]     mac_a,
  output logic [BITS-1:0]     mac_b,
  input  logic [2*BITS-1:0]   mac_result,
  input  logic                mac_done,
  output logic                busy,
  output logic                out_valid,
  output logic [ACC_BITS-1:0] result,
  output state_e              dbg_state
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q;
  logic [ADDR_W-1:0]   a_base_q, b_base_q;
  logic [LEN_W-1:0]    issue_cnt_q;
  logic [LEN_W-1:0]    done_cnt_q;
  logic                mac_en_q;
  logic [ACC_BITS-1:0] result_q;
  logic [ACC_BITS-1:0] acc;
  logic                accept;
  logic                count_en;

  // Next-state and control decode; done pulses count only in ISSUE/DRAIN and
  // only until N have been seen, so stale or surplus pulses are dropped.
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    count_en  = (state_q == ISSUE || state_q == DRAIN) && mac_done &&
                (done_cnt_q != len_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        rd_en = 1'b1;
        if (issue_cnt_q == len_q - LEN_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (done_cnt_q == len_q ||
            (count_en && (done_cnt_q + LEN_W'(1)) == len_q)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand capture and issue/done counters; all restart on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      issue_cnt_q <= '0;
      done_cnt_q  <= '0;
    end else if (accept) begin
      len_q       <= len;
      a_base_q    <= a_base;
      b_base_q    <= b_base;
      issue_cnt_q <= '0;
      done_cnt_q  <= '0;
    end else begin
      if (rd_en)    issue_cnt_q <= issue_cnt_q + LEN_W'(1);
      if (count_en) done_cnt_q  <= done_cnt_q + LEN_W'(1);
    end
  end

  // Operand-valid follows the read strobe by the buffer read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mac_en_q <= 1'b0;
    else        mac_en_q <= rd_en;
  end

  // Hold the last completed sum for the layer controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                result_q <= '0;
    else if (state_q == DONE)  result_q <= acc;
  end

  dot_accumulator #(
    .IN_W  (2*BITS),
    .ACC_W (ACC_BITS)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .add_en (count_en),
    .din    (mac_result),
    .acc    (acc)
  );

  // Output drive: addresses wrap naturally at ADDR_W; result shows the final
  // sum already in the DONE cycle so it lines up with out_valid.
  always_comb begin
    a_addr     = a_base_q + ADDR_W'(issue_cnt_q);
    b_addr     = b_base_q + ADDR_W'(issue_cnt_q);
    mac_enable = mac_en_q;
    mac_a      = a_rdata;
    mac_b      = b_rdata;
    busy       = (state_q != IDLE);
    result     = (state_q == DONE) ? acc : result_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_mac_dot_scheduler.sv
// Bench for mac_dot_scheduler: buffer and 2-stage MAC models, directed runs
// with a result scoreboard and per-run timing/address checks.
module tb_mac_dot_scheduler;
  import mac_dot_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [9:0]  a_base = '0, b_base = '0;
  logic        rd_en;
  logic [9:0]  a_addr, b_addr;
  logic [7:0]  a_rdata, b_rdata;
  logic        mac_enable;
  logic [7:0]  mac_a, mac_b;
  logic [15:0] mac_result;
  logic        mac_done;
  logic        busy, out_valid;
  logic [23:0] result;
  state_e      dbg_state;

  logic signed [7:0] a_mem [0:1023];
  logic signed [7:0] b_mem [0:1023];
  logic [23:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic        inject = 1'b0;
  logic signed [15:0] p1, p2;
  logic        v1, v2;

  mac_dot_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .a_base(a_base), .b_base(b_base), .rd_en(rd_en),
    .a_addr(a_addr), .b_addr(b_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mac_enable(mac_enable), .mac_a(mac_a), .mac_b(mac_b),
    .mac_result(mac_result), .mac_done(mac_done), .busy(busy),
    .out_valid(out_valid), .result(result), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Synchronous 1-cycle-read buffers.
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= a_mem[a_addr];
      b_rdata <= b_mem[b_addr];
    end
  end

  // Two-stage signed MAC, reset from ~rst_n; inject forces a stray done pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; p1 <= '0; p2 <= '0;
    end else begin
      v1 <= mac_enable;
      p1 <= $signed(mac_a) * $signed(mac_b);
      v2 <= v1;
      p2 <= p1;
    end
  end
  assign mac_done   = v2 | inject;
  assign mac_result = inject ? 16'h7FFF : p2;

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] dot_model(input int n, input int ab, input int bb);
    int s = 0;
    for (int i = 0; i < n; i++)
      s += int'(a_mem[(ab + i) % 1024]) * int'(b_mem[(bb + i) % 1024]);
    return 24'(s);
  endfunction

  // One operation: start in cycle 0, sample each cycle at negedge until
  // out_valid. poke_cyc > 0 pulses start (len=7, other bases) in that cycle.
  task automatic run_op(input int n, input int ab, input int bb,
                        input logic [23:0] exp_res, input int poke_cyc, input string tag);
    int rd_cnt = 0, en_cnt = 0, ov_cyc = -1, first_rd = -1, first_en = -1, bad = 0;
    int exp_ov;
    logic [23:0] e;
    exp_ov = (n == 0) ? 1 : n + 4;
    @(posedge clk); #1;
    start = 1'b1; len = n[7:0]; a_base = ab[9:0]; b_base = bb[9:0];
    exp_q.push_back(exp_res);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= n + 30; cyc++) begin
      if (cyc == poke_cyc) begin
        start = 1'b1; len = 8'd7; a_base = 10'd500; b_base = 10'd600;
      end
      @(negedge clk);
      if (rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        if (a_addr !== 10'(ab + rd_cnt - 1)) bad++;
        if (b_addr !== 10'(bb + rd_cnt - 1)) bad++;
      end
      if (mac_enable) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        if (mac_a !== a_mem[(ab + en_cnt - 1) % 1024]) bad++;
        if (mac_b !== b_mem[(bb + en_cnt - 1) % 1024]) bad++;
      end
      if (out_valid) begin
        ov_cyc = cyc;
        if (exp_q.size() == 0) begin
          check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_result"}, 32'(result), 32'(e));
        end
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    start = 1'b0;
    check({tag, "_ov_cycle"}, 32'(ov_cyc), 32'(exp_ov));
    check({tag, "_rd_count"}, 32'(rd_cnt), 32'(n));
    check({tag, "_en_count"}, 32'(en_cnt), 32'(n));
    check({tag, "_rd_first"}, 32'(first_rd), (n == 0) ? 32'hFFFF_FFFF : 32'd1);
    check({tag, "_en_first"}, 32'(first_en), (n == 0) ? 32'hFFFF_FFFF : 32'd2);
    check({tag, "_addr_data"}, 32'(bad), 32'd0);
  endtask

  task automatic load_ab(input int ab, input int bb, input int n,
                         input logic signed [7:0] av[], input logic signed [7:0] bv[]);
    for (int i = 0; i < n; i++) begin
      a_mem[(ab + i) % 1024] = av[i];
      b_mem[(bb + i) % 1024] = bv[i];
    end
  endtask

  initial begin
    int n, ab, bb;
    logic signed [7:0] av[], bv[];
    for (int i = 0; i < 1024; i++) begin a_mem[i] = '0; b_mem[i] = '0; end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_mac_en", 32'(mac_enable), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // Basic 4-element dot product.
    av = '{1, 2, 3, 4}; bv = '{5, 6, 7, 8};
    load_ab(0, 16, 4, av, bv);
    run_op(4, 0, 16, 24'd70, 0, "len4");

    // Back-to-back: starts the cycle after out_valid.
    av = '{-128, -128}; bv = '{-128, 127};
    load_ab(0, 16, 2, av, bv);
    run_op(2, 0, 16, 24'd128, 0, "len2");

    av = '{-1}; bv = '{127};
    load_ab(0, 16, 1, av, bv);
    run_op(1, 0, 16, 24'(-127), 0, "len1");

    // Zero length.
    run_op(0, 0, 16, 24'd0, 0, "len0");

    // Full length at the most negative operands, A address wrap 1023->0.
    av = new[255]; bv = new[255];
    for (int i = 0; i < 255; i++) begin av[i] = -128; bv[i] = -128; end
    load_ab(1020, 300, 255, av, bv);
    run_op(255, 1020, 300, 24'd4177920, 0, "len255");

    // Start mid-ISSUE must be ignored, and start during DONE too.
    av = '{1, 2, 3, 4}; bv = '{5, 6, 7, 8};
    load_ab(0, 16, 4, av, bv);
    run_op(4, 0, 16, 24'd70, 2, "poke_issue");
    run_op(4, 0, 16, 24'd70, 8, "poke_done");
    @(posedge clk); #1;
    check("done_start_ignored_busy", 32'(busy), 32'd0);
    check("done_start_ignored_state", 32'(dbg_state), 32'(IDLE));
    check("result_held", 32'(result), 32'd70);

    // Random vectors against the model.
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(3, 12); ab = $urandom_range(0, 1023); bb = $urandom_range(0, 1023);
      for (int i = 0; i < n; i++) begin
        a_mem[(ab + i) % 1024] = 8'($urandom_range(0, 255));
        b_mem[(bb + i) % 1024] = 8'($urandom_range(0, 255));
      end
      run_op(n, ab, bb, dot_model(n, ab, bb), 0, "rand");
    end

    // Nonzero result so the reset clear is visible.
    av = '{-1}; bv = '{127};
    load_ab(0, 16, 1, av, bv);
    run_op(1, 0, 16, 24'(-127), 0, "pre_abort");

    // Abort during DRAIN.
    av = '{1, 2, 3, 4}; bv = '{5, 6, 7, 8};
    load_ab(0, 16, 4, av, bv);
    @(posedge clk); #1;
    start = 1'b1; len = 8'd4; a_base = 10'd0; b_base = 10'd16;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_in_drain", 32'(dbg_state), 32'(DRAIN));
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Stray done pulses while idle must not disturb anything.
    inject = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    inject = 1'b0;
    check("stale_busy", 32'(busy), 32'd0);
    check("stale_result", 32'(result), 32'd0);
    run_op(4, 0, 16, 24'd70, 0, "after_abort");

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
